// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker for a Galois LFSR generator with the feedback mask TAPS.
// Optional feature: define PRBS_CHK_BITCNT_EN to count the bits checked while locked in bit_count.
module prbs_checker #(
   parameter TAPS         = 16'b0000000000011101,
   parameter int LOCK_CNT = 32,
   parameter int LOSS_CNT = 8,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [31:0]      bit_count
);

   localparam int NBITS = $bits(TAPS);
   localparam int FW    = $clog2(NBITS + 1);

   localparam logic [NBITS-1:0] TAP_MASK  = NBITS'(TAPS);
   localparam logic [FW-1:0]    FILL_FULL = FW'(NBITS);
   localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CNT - 1);
   localparam logic [7:0]       LOSS_LAST = 8'(LOSS_CNT - 1);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t           state;
   logic [NBITS-1:0] hist;
   logic [FW-1:0]    fill;
   logic [7:0]       match_run;
   logic [7:0]       miss_run;
   logic             pred;
   logic             mismatch;
   logic             filled;
   logic             bad;

   assign pred     = ^(hist & TAP_MASK);
   assign mismatch = in_bit ^ pred;
   assign filled   = (fill == FILL_FULL);
   assign bad      = in_valid && (state == LOCKED) && mismatch;
   assign locked   = (state == LOCKED);

   // NOTE: every register here, hist included, is cleared by the synchronous reset
   // and assigned only with <= so all state advances together on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= SEARCH;
         hist      <= '0;
         fill      <= '0;
         match_run <= '0;
         miss_run  <= '0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         err_pulse <= 1'b0;

         // A clear coinciding with an error leaves exactly that error counted.
         if (clear_cnt)
            err_count <= bad ? ERR_W'(1) : '0;
         else if (bad && (err_count != '1))
            err_count <= err_count + ERR_W'(1);

         if (in_valid) begin
            unique case (state)
               SEARCH: begin
                  hist <= {in_bit, hist[NBITS-1:1]};
                  if (!filled)
                     fill <= fill + FW'(1);
                  else if (mismatch)
                     match_run <= '0;
                  else if (match_run == LOCK_LAST) begin
                     state     <= LOCKED;
                     match_run <= '0;
                     miss_run  <= '0;
                  end else
                     match_run <= match_run + 8'd1;
               end
               LOCKED: begin
                  // Flywheel: the prediction, not the line bit, feeds the history.
                  hist <= {pred, hist[NBITS-1:1]};
                  if (mismatch) begin
                     err_pulse <= 1'b1;
                     if ((LOSS_CNT != 0) && (miss_run == LOSS_LAST)) begin
                        state     <= SEARCH;
                        fill      <= '0;
                        match_run <= '0;
                        miss_run  <= '0;
                     end else
                        miss_run <= miss_run + 8'd1;
                  end else
                     miss_run <= '0;
               end
            endcase
         end
      end
   end

`ifdef PRBS_CHK_BITCNT_EN
   logic counted;

   assign counted = in_valid && (state == LOCKED);

   always_ff @(posedge clk) begin
      if (!rst_n)
         bit_count <= '0;
      else if (clear_cnt)
         bit_count <= counted ? 32'd1 : 32'd0;
      else if (counted)
         bit_count <= bit_count + 32'd1;
   end
`else
   assign bit_count = '0;
`endif

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial pseudo-random bit-sequence checker: the receive end of the Galois LFSR generator used as a test-pattern source. It consumes one bit per qualified cycle, synchronises itself to the sequence without a seed, and then counts bit errors against a locally predicted sequence. It sits on the loopback/self-test path, downstream of the serialised generator output, and reports lock and error status to the status register block.

## Interface
- `TAPS`, 16'b0000000000011101: feedback polynomial bitmask, the same value the generator uses; bit 0 must be 1.
- `NBITS`, $size(TAPS): register width; derived, never overridden.
- `LOCK_CNT`, 32: consecutive matching bits required to declare lock (1..255).
- `LOSS_CNT`, 8: consecutive mismatching bits that drop lock (0..255); 0 means lock is never dropped.
- `ERR_W`, 16: error counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: `in_bit` is qualified this cycle.
- `in_bit` in 1: received bit, which is generator MSB before each shift.
- `clear_cnt` in 1: synchronous clear of `err_count` (and `bit_count`).
- `locked` out 1: checker is in LOCKED.
- `err_pulse` out 1: one-cycle pulse per mismatched bit while LOCKED.
- `err_count` out ERR_W: saturating count of mismatches while LOCKED.
- `bit_count` out 32: bits checked while LOCKED (see Configuration).

## Operation
- Sequence law: for generator output s, s[t+N] = XOR over j of TAPS[j]·s[t+j], where N = NBITS.
- History register `hist[N-1:0]`: hist[N-1] holds the newest bit and hist[0] the oldest. Prediction is `pred = ^(hist & TAPS)`.
- A shift inserts a bit at [N-1], moving the rest toward [0]. Nothing changes on cycles with `in_valid`=0.
- SEARCH (the reset state):
  - Every valid bit shifts the received `in_bit` into hist.
  - A fill counter counts to N; no comparison is made until hist holds N bits.
  - After fill, each valid bit is compared with `pred`. A match increments `match_run`; a mismatch clears it.
  - When `match_run` reaches LOCK_CNT, the state goes to LOCKED.
- LOCKED (flywheel):
  - Every valid bit shifts `pred` into hist, not `in_bit`, so each line error is counted exactly once.
  - On a mismatch: `err_pulse`, `err_count`+1 (saturating at all-ones), `miss_run`+1.
  - On a match: `miss_run` is cleared.
  - When `miss_run` reaches LOSS_CNT (LOSS_CNT≠0), the state goes to SEARCH. Fill counter, `match_run` and `miss_run` are cleared; `err_count` is kept.
- `clear_cnt` zeroes the counters. If an error occurs in the same cycle, the counter is loaded with 1 instead.
- Reset:
  - `rst_n`=0 at any point, including mid-lock, forces SEARCH, zero fill and runs, and zero hist.
  - All outputs are 0 on the following cycle.

## Timing
- All outputs are registered.
- `err_pulse` is high in the cycle after the edge that sampled the bad bit.
- `err_count` updates on that same edge.
- Lock latency on a clean stream: `locked` rises the cycle after the (N+LOCK_CNT)-th valid bit. That is 48 valid bits at the defaults.
- Loss: `locked` falls the cycle after the LOSS_CNT-th consecutive mismatch. That mismatch is still counted and pulsed.
- Gaps in `in_valid` have no effect beyond stretching time. There is no timeout.

## Configuration
- Macro: `PRBS_CHK_BITCNT_EN`.
- Defined:
  - `bit_count` increments (wrapping at 2^32) on every valid bit while LOCKED, including the bit that causes loss.
  - It is cleared by `clear_cnt` and by reset.
- Undefined:
  - The counter logic is absent and `bit_count` is driven constant 0.
  - The port always exists.

## Test plan
- Clean lock:
  - Stimulus: generator TAPS 16'h001D seeded 16'hFFFF, 64 continuous valid bits.
  - Response: `locked` rises after valid bit 48; `err_count`=0; with the macro, `bit_count`=16 after 64 bits.
- Single error:
  - Stimulus: after lock, invert one bit.
  - Response: exactly one `err_pulse`; `err_count`=1; `locked` stays 1 and later bits match.
- Loss and relock:
  - Stimulus: after lock, invert 8 consecutive bits, then a clean stream.
  - Response: `err_count`=8; `locked` falls after the 8th; it relocks 48 valid bits after the inversions end.
- Valid gaps:
  - Stimulus: a clean stream with `in_valid` toggling 1,0,1,0.
  - Response: lock after the 48th valid bit (about cycle 96); no errors.
- Reset and clear:
  - Stimulus: `rst_n`=0 for 1 cycle while locked with `err_count`=3.
  - Response: next cycle `locked`=0 and `err_count`=0.
  - Stimulus: `clear_cnt` in the same cycle as a mismatch.
  - Response: `err_count`=1.
- Saturation:
  - Stimulus: ERR_W=4, LOSS_CNT=0, after lock feed 20 inverted bits.
  - Response: `err_count`=15 and holds; `locked` stays 1; 20 `err_pulse` pulses.
